pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage RV64 pipeline (F, D, E, M, W). It generates the per-stage pipeline-register enables and flushes, and the E-stage operand forwarding selects. It serialises `ecall` so the call executes at W with no younger instructions in flight. Sits beside the decode/register-file/writeback stage and drives its `enableD`/`enableW` along with the other stage enables.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/pipeline_ctrl_if.sv | 28 ++
 rtl/pipeline_ctrl_fwd_sel.sv | 20 ++
 rtl/pipeline_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the five-stage RV64 hazard/sequencing controller.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        ECALL_DRAIN = 2'd1,
        MEM_WAIT    = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_W      = 2'b01;
    localparam logic [1:0] FWD_M      = 2'b10;
    localparam logic [1:0] RESULT_MEM = 2'b01;

    // A live writer to a real register (x0 never counts) that a reader depends on.
    function automatic logic regMatch(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Datapath <-> hazard controller bus: register/stage info in, stage enables, flushes
// and E-stage forward selects out.
interface pipeline_ctrl_if;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, EcallD, EcallW;
    logic       imem_busy, dmem_busy;
    logic       enableF, enableD, enableE, enableM, enableW;
    logic       flushD, flushE;
    logic [1:0] ForwardAE, ForwardBE;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteE, RegWriteM, RegWriteW, ResultSrcE,
        output PCSrcE, EcallD, EcallW, imem_busy, dmem_busy,
        input  enableF, enableD, enableE, enableM, enableW,
        input  flushD, flushE, ForwardAE, ForwardBE
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE,
        input  PCSrcE, EcallD, EcallW, imem_busy, dmem_busy,
        output enableF, enableD, enableE, enableM, enableW,
        output flushD, flushE, ForwardAE, ForwardBE
    );
endinterface

// File: rtl/pipeline_ctrl_fwd_sel.sv
// E-stage operand forward select: the M-stage writer wins over the W-stage writer.
module fwd_sel
    import pipeline_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rdM,
    input  logic       regWriteM,
    input  logic [4:0] rdW,
    input  logic       regWriteW,
    output logic [1:0] sel
);
    always_comb begin
        sel = FWD_RF;
        if (regMatch(regWriteM, rdM, rs)) begin
            sel = FWD_M;
        end else if (regMatch(regWriteW, rdW, rs)) begin
            sel = FWD_W;
        end
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the F/D/E/M/W pipeline: stage enables, flushes,
// forward selects, ecall serialisation. Define PIPELINE_CTRL_FORWARD_EN to enable forwarding.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    pipeline_ctrl_if.slave   bus,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    ctrl_state_t state, stateNext, saved, savedNext, effState;
    logic        busy, hazard;
    logic        enF, enD, enE, enM, enW, flD, flE;
    logic [1:0]  fwdA, fwdB, fwdOutA, fwdOutB;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt, input logic inc);
        return (inc && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
    endfunction

    fwd_sel fwdSelA (
        .rs(bus.Rs1E), .rdM(bus.RdM), .regWriteM(bus.RegWriteM),
        .rdW(bus.RdW), .regWriteW(bus.RegWriteW), .sel(fwdA)
    );

    fwd_sel fwdSelB (
        .rs(bus.Rs2E), .rdM(bus.RdM), .regWriteM(bus.RegWriteM),
        .rdW(bus.RdW), .regWriteW(bus.RegWriteW), .sel(fwdB)
    );

`ifdef PIPELINE_CTRL_FORWARD_EN
    // Only a load in E cannot be forwarded in time; hold D for one cycle.
    assign hazard = (bus.ResultSrcE == RESULT_MEM) &&
                    (regMatch(bus.RegWriteE, bus.RdE, bus.Rs1D) ||
                     regMatch(bus.RegWriteE, bus.RdE, bus.Rs2D));
    assign fwdOutA = fwdA;
    assign fwdOutB = fwdB;
`else
    // Without forwarding, hold D until E and M writers have drained; W is bypassed in the RF.
    logic unusedFwdIn;
    assign hazard = regMatch(bus.RegWriteE, bus.RdE, bus.Rs1D) ||
                    regMatch(bus.RegWriteE, bus.RdE, bus.Rs2D) ||
                    regMatch(bus.RegWriteM, bus.RdM, bus.Rs1D) ||
                    regMatch(bus.RegWriteM, bus.RdM, bus.Rs2D);
    assign fwdOutA = FWD_RF;
    assign fwdOutB = FWD_RF;
    assign unusedFwdIn = ^{fwdA, fwdB, (bus.ResultSrcE == RESULT_MEM)};
`endif

    assign busy = bus.imem_busy || bus.dmem_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            saved <= RUN;
        end else begin
            state <= stateNext;
            saved <= savedNext;
        end
    end

    always_comb begin
        stateNext = state;
        savedNext = saved;
        enF       = 1'b1;
        enD       = 1'b1;
        enE       = 1'b1;
        enM       = 1'b1;
        enW       = 1'b1;
        flD       = 1'b0;
        flE       = 1'b0;
        // The cycle leaving MEM_WAIT behaves as the state that was interrupted.
        effState  = (state == MEM_WAIT) ? saved : state;
        if (busy) begin
            {enF, enD, enE, enM, enW} = 5'b00000;
            stateNext = MEM_WAIT;
            if (state != MEM_WAIT) begin
                savedNext = state;
            end
        end else begin
            stateNext = effState;
            if ((effState == ECALL_DRAIN) && bus.EcallW) begin
                stateNext = RUN;
            end
            if (bus.PCSrcE) begin
                flD = 1'b1;
                flE = 1'b1;
            end else if (hazard) begin
                enF = 1'b0;
                enD = 1'b0;
                flE = 1'b1;
            end else if ((effState == RUN) && bus.EcallD) begin
                enF       = 1'b0;
                flD       = 1'b1;
                stateNext = ECALL_DRAIN;
            end else if (effState == ECALL_DRAIN) begin
                enF = 1'b0;
                flD = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= satInc(stall_cnt, !enF);
            flush_cnt <= satInc(flush_cnt, bus.PCSrcE && !busy);
        end
    end

    // Reset forces every stage to hold a bubble.
    assign bus.enableF   = reset_n && enF;
    assign bus.enableD   = reset_n && enD;
    assign bus.enableE   = reset_n && enE;
    assign bus.enableM   = reset_n && enM;
    assign bus.enableW   = reset_n && enW;
    assign bus.flushD    = !reset_n || flD;
    assign bus.flushE    = !reset_n || flE;
    assign bus.ForwardAE = reset_n ? fwdOutA : FWD_RF;
    assign bus.ForwardBE = reset_n ? fwdOutB : FWD_RF;
    assign ctrl_state    = state;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed multi-cycle sequences,
// and randomized cycles against a rule-level reference model.
module tb_pipeline_ctrl;
    localparam int          CNT_W   = 4;
    localparam logic [63:0] CNT_MAX = 64'd15;
`ifdef PIPELINE_CTRL_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE;
        logic       regWriteE;
        logic [1:0] resultSrcE;
        logic [4:0] rdM;
        logic       regWriteM;
        logic [4:0] rdW;
        logic       regWriteW;
        logic       pcSrcE, ecallD, ecallW, imemBusy, dmemBusy;
    } in_t;

    typedef struct packed {
        logic [4:0] en;      // {F, D, E, M, W}
        logic       flushD;
        logic       flushE;
        logic [1:0] fa;
        logic [1:0] fb;
    } out_t;

    typedef struct {
        in_t        in;
        logic [4:0] en;
        logic [1:0] fl;      // {flushD, flushE}
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    logic             clk;
    logic             reset_n;
    logic [1:0]       ctrlState;
    logic [CNT_W-1:0] stallCnt, flushCnt;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .ctrl_state(ctrlState), .stall_cnt(stallCnt), .flush_cnt(flushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          mState, mSaved;   // 0 run, 1 ecall drain, 2 memory wait
    logic [63:0] mStall, mFlush;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic in_t idle();
        in_t v;
        v = '0;
        return v;
    endfunction

    function automatic in_t randIn();
        in_t v;
        v.rs1D = 5'($urandom_range(0, 7));
        v.rs2D = 5'($urandom_range(0, 7));
        v.rs1E = 5'($urandom_range(0, 7));
        v.rs2E = 5'($urandom_range(0, 7));
        v.rdE  = 5'($urandom_range(0, 7));
        v.rdM  = 5'($urandom_range(0, 7));
        v.rdW  = 5'($urandom_range(0, 7));
        v.regWriteE  = 1'($urandom_range(0, 1));
        v.regWriteM  = 1'($urandom_range(0, 1));
        v.regWriteW  = 1'($urandom_range(0, 1));
        v.resultSrcE = 2'($urandom_range(0, 3));
        v.pcSrcE   = ($urandom_range(0, 7) == 0);
        v.ecallD   = ($urandom_range(0, 4) == 0);
        v.ecallW   = ($urandom_range(0, 5) == 0);
        v.imemBusy = ($urandom_range(0, 11) == 0);
        v.dmemBusy = ($urandom_range(0, 11) == 0);
        return v;
    endfunction

    // Hazard rule as stated: a load in E feeding D (forwarding build), or any E/M writer
    // feeding D (non-forwarding build). x0 never counts.
    function automatic logic refHazard(input in_t v);
        logic dReadsE, dReadsM;
        dReadsE = (v.rdE != 0) && ((v.rdE == v.rs1D) || (v.rdE == v.rs2D));
        dReadsM = (v.rdM != 0) && ((v.rdM == v.rs1D) || (v.rdM == v.rs2D));
        if (FWD) return v.regWriteE && (v.resultSrcE == 2'b01) && dReadsE;
        return (v.regWriteE && dReadsE) || (v.regWriteM && dReadsM);
    endfunction

    function automatic logic [1:0] refFwd(input logic [4:0] rs, input in_t v);
        if (!FWD || rs == 0) return 2'b00;
        if (v.regWriteM && v.rdM == rs) return 2'b10;
        if (v.regWriteW && v.rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic out_t refOut(input in_t v);
        out_t o;
        int   eff;
        eff      = (mState == 2) ? mSaved : mState;
        o.en     = 5'b11111;
        o.flushD = 1'b0;
        o.flushE = 1'b0;
        o.fa     = refFwd(v.rs1E, v);
        o.fb     = refFwd(v.rs2E, v);
        if (v.imemBusy || v.dmemBusy) begin
            o.en = 5'b00000;
        end else if (v.pcSrcE) begin
            o.flushD = 1'b1;
            o.flushE = 1'b1;
        end else if (refHazard(v)) begin
            o.en[4:3] = 2'b00;
            o.flushE  = 1'b1;
        end else if (eff == 1 || (eff == 0 && v.ecallD)) begin
            o.en[4]  = 1'b0;
            o.flushD = 1'b1;
        end
        return o;
    endfunction

    task automatic modelAdvance(input in_t v);
        out_t o;
        int   eff;
        logic busy;
        o    = refOut(v);
        eff  = (mState == 2) ? mSaved : mState;
        busy = v.imemBusy || v.dmemBusy;
        if (!o.en[4] && mStall < CNT_MAX) mStall++;
        if (v.pcSrcE && !busy && mFlush < CNT_MAX) mFlush++;
        if (busy) begin
            if (mState != 2) mSaved = mState;
            mState = 2;
        end else if (eff == 1) begin
            mState = v.ecallW ? 0 : 1;
        end else if (v.ecallD && !v.pcSrcE && !refHazard(v)) begin
            mState = 1;
        end else begin
            mState = 0;
        end
    endtask

    function automatic out_t readOut();
        out_t o;
        o.en     = {bus.enableF, bus.enableD, bus.enableE, bus.enableM, bus.enableW};
        o.flushD = bus.flushD;
        o.flushE = bus.flushE;
        o.fa     = bus.ForwardAE;
        o.fb     = bus.ForwardBE;
        return o;
    endfunction

    task automatic drive(input in_t v);
        bus.Rs1D = v.rs1D;  bus.Rs2D = v.rs2D;  bus.Rs1E = v.rs1E;  bus.Rs2E = v.rs2E;
        bus.RdE = v.rdE;    bus.RegWriteE = v.regWriteE;  bus.ResultSrcE = v.resultSrcE;
        bus.RdM = v.rdM;    bus.RegWriteM = v.regWriteM;
        bus.RdW = v.rdW;    bus.RegWriteW = v.regWriteW;
        bus.PCSrcE = v.pcSrcE;  bus.EcallD = v.ecallD;  bus.EcallW = v.ecallW;
        bus.imem_busy = v.imemBusy;  bus.dmem_busy = v.dmemBusy;
    endtask

    // Drive a cycle's inputs and compare everything against the model before the edge.
    task automatic applyIn(input in_t v, input string tag);
        out_t e, a;
        drive(v);
        #3;
        e = refOut(v);
        a = readOut();
        chk({tag, " enables"}, a.en, e.en);
        chk({tag, " flushes"}, {a.flushD, a.flushE}, {e.flushD, e.flushE});
        chk({tag, " ForwardAE"}, a.fa, e.fa);
        chk({tag, " ForwardBE"}, a.fb, e.fb);
        chk({tag, " ctrl_state"}, ctrlState, mState);
        chk({tag, " stall_cnt"}, stallCnt, mStall);
        chk({tag, " flush_cnt"}, flushCnt, mFlush);
    endtask

    task automatic clockIt(input in_t v);
        @(posedge clk);
        modelAdvance(v);
        #1;
    endtask

    task automatic doReset();
        drive(idle());
        reset_n = 1'b0;
        #1;
        chk("reset enables", {bus.enableF, bus.enableD, bus.enableE, bus.enableM, bus.enableW}, 0);
        chk("reset flushes", {bus.flushD, bus.flushE}, 2'b11);
        chk("reset state/counters", {ctrlState, stallCnt, flushCnt}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mState = 0; mSaved = 0; mStall = 0; mFlush = 0;
    endtask

    vec_t tbl[$];
    vec_t t;
    in_t  v;

    initial begin
        reset_n = 1'b0;
        drive(idle());

        // Single-cycle vectors in RUN; expectations depend on the build's forwarding mode.
        t.in = idle(); t.en = 5'b11111; t.fl = 2'b00; t.fa = 2'b00; t.fb = 2'b00; tbl.push_back(t);
        t.in.rdM = 5; t.in.regWriteM = 1; t.in.rdW = 5; t.in.regWriteW = 1; t.in.rs1E = 5;
        t.fa = FWD ? 2'b10 : 2'b00; tbl.push_back(t);
        t.in.rdM = 0; t.fa = FWD ? 2'b01 : 2'b00; tbl.push_back(t);
        t.in = idle(); t.in.rs2E = 9; t.in.rdW = 9; t.in.regWriteW = 1;
        t.fa = 2'b00; t.fb = FWD ? 2'b01 : 2'b00; tbl.push_back(t);
        t.in = idle(); t.in.regWriteM = 1; t.fb = 2'b00; tbl.push_back(t);
        t.in = idle(); t.in.rdE = 7; t.in.regWriteE = 1; t.in.resultSrcE = 2'b01; t.in.rs2D = 7;
        t.en = 5'b00111; t.fl = 2'b01; tbl.push_back(t);
        t.in.pcSrcE = 1; t.en = 5'b11111; t.fl = 2'b11; tbl.push_back(t);
        t.in = idle(); t.in.pcSrcE = 1; tbl.push_back(t);
        t.in = idle(); t.in.rdE = 7; t.in.regWriteE = 1; t.in.rs1D = 7;
        t.en = FWD ? 5'b11111 : 5'b00111; t.fl = FWD ? 2'b00 : 2'b01; tbl.push_back(t);
        t.in = idle(); t.in.rdM = 3; t.in.regWriteM = 1; t.in.rs1D = 3; t.in.rs1E = 3;
        t.fa = FWD ? 2'b10 : 2'b00; tbl.push_back(t);
        t.in = idle(); t.in.regWriteE = 1; t.in.resultSrcE = 2'b01;
        t.en = 5'b11111; t.fl = 2'b00; t.fa = 2'b00; tbl.push_back(t);
        t.in = idle(); t.in.rdW = 4; t.in.regWriteW = 1; t.in.rs1D = 4; tbl.push_back(t);
        t.in = idle(); t.in.rdE = 7; t.in.resultSrcE = 2'b01; t.in.rs1D = 7; tbl.push_back(t);
        t.in = idle(); t.in.rs1E = 6; t.in.rs2E = 6; t.in.rdM = 6; t.in.regWriteM = 1;
        t.in.rdW = 6; t.in.regWriteW = 1;
        t.fa = FWD ? 2'b10 : 2'b00; t.fb = FWD ? 2'b10 : 2'b00; tbl.push_back(t);

        doReset();

        foreach (tbl[i]) begin
            drive(tbl[i].in);
            #3;
            chk($sformatf("vec%0d enables", i),
                {bus.enableF, bus.enableD, bus.enableE, bus.enableM, bus.enableW}, tbl[i].en);
            chk($sformatf("vec%0d flushes", i), {bus.flushD, bus.flushE}, tbl[i].fl);
            chk($sformatf("vec%0d ForwardAE", i), bus.ForwardAE, tbl[i].fa);
            chk($sformatf("vec%0d ForwardBE", i), bus.ForwardBE, tbl[i].fb);
            chk($sformatf("vec%0d ctrl_state", i), ctrlState, 0);
            clockIt(tbl[i].in);
        end

        // Load-use: one bubble, then free flow.
        doReset();
        v = idle(); v.rdE = 7; v.regWriteE = 1; v.resultSrcE = 2'b01; v.rs2D = 7;
        applyIn(v, "loaduse");
        chk("loaduse stall pattern", {bus.enableF, bus.enableD, bus.flushE}, 3'b001);
        clockIt(v);
        applyIn(idle(), "loaduse after");
        chk("loaduse after enables", {bus.enableF, bus.enableD, bus.enableE, bus.enableM, bus.enableW}, 5'b11111);
        chk("loaduse stall_cnt", stallCnt, 1);
        clockIt(idle());

        // Load-use cancelled by a redirect.
        doReset();
        v.pcSrcE = 1;
        applyIn(v, "redirect");
        chk("redirect pattern", {bus.flushD, bus.flushE, bus.enableF}, 3'b111);
        clockIt(v);
        applyIn(idle(), "redirect after");
        chk("redirect counters", {flushCnt, stallCnt}, {4'd1, 4'd0});
        clockIt(idle());

        // Ecall: entry plus three drain cycles with fetch stalled.
        doReset();
        for (int c = 0; c < 5; c++) begin
            v = idle(); v.ecallD = (c == 0); v.ecallW = (c == 3);
            applyIn(v, $sformatf("ecall c%0d", c));
            chk($sformatf("ecall c%0d enableF", c), bus.enableF, (c == 4));
            chk($sformatf("ecall c%0d state", c), ctrlState, (c >= 1 && c <= 3) ? 1 : 0);
            clockIt(v);
        end
        chk("ecall stall_cnt", stallCnt, 4);

        // Data memory busy for three cycles in the middle of the drain.
        doReset();
        for (int c = 0; c < 8; c++) begin
            v = idle(); v.ecallD = (c == 0); v.dmemBusy = (c >= 2 && c <= 4); v.ecallW = (c == 6);
            applyIn(v, $sformatf("drainbusy c%0d", c));
            if (c >= 2 && c <= 4)
                chk($sformatf("drainbusy c%0d enables", c),
                    {bus.enableF, bus.enableD, bus.enableE, bus.enableM, bus.enableW}, 0);
            chk($sformatf("drainbusy c%0d state", c), ctrlState,
                (c == 3 || c == 4 || c == 5) ? 2 : (c == 0 || c == 7) ? 0 : 1);
            clockIt(v);
        end
        chk("drainbusy stall_cnt", stallCnt, 7);

        // EcallW coinciding with dmem_busy is re-sampled after the wait.
        doReset();
        for (int c = 0; c < 6; c++) begin
            v = idle(); v.ecallD = (c == 0); v.ecallW = (c == 3 || c == 4); v.dmemBusy = (c == 3);
            applyIn(v, $sformatf("ecallw busy c%0d", c));
            chk($sformatf("ecallw busy c%0d state", c), ctrlState,
                (c == 4) ? 2 : (c == 0 || c == 5) ? 0 : 1);
            clockIt(v);
        end

        // Reset asserted mid-drain takes effect immediately.
        doReset();
        v = idle(); v.ecallD = 1;
        applyIn(v, "rstdrain entry");
        clockIt(v);
        v = idle(); v.rs1E = 5; v.rdM = 5; v.regWriteM = 1;
        applyIn(v, "rstdrain drain");
        reset_n = 1'b0;
        #1;
        chk("rstdrain enables", {bus.enableF, bus.enableD, bus.enableE, bus.enableM, bus.enableW}, 0);
        chk("rstdrain flushes", {bus.flushD, bus.flushE}, 2'b11);
        chk("rstdrain forwards", {bus.ForwardAE, bus.ForwardBE}, 0);
        chk("rstdrain state/counters", {ctrlState, stallCnt, flushCnt}, 0);
        mState = 0; mSaved = 0; mStall = 0; mFlush = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyIn(idle(), "rstdrain release");
        clockIt(idle());

        // Randomized traffic, including counter saturation.
        for (int c = 0; c < 600; c++) begin
            v = randIn();
            applyIn(v, $sformatf("rand c%0d", c));
            clockIt(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
